ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Single-clock FIFO controller that drives one external `sync_dp_ram` instance, with both RAM clocks tied to `clk`. It turns that RAM into a valid/ready FIFO. It generates the RAM write and read strobes and addresses, and absorbs the RAM's 1-cycle read latency with an internal 2-entry output skid buffer. This sustains one word per cycle in and out. It sits between an upstream producer (e.g. a bitstream or rate-buffer writer) and a downstream consumer, next to the RAM it controls.

## Interface
- `NUMBER_OF_LINES`, 16, RAM depth; power of two, ≥4; must match the attached RAM.
- `DATA_WIDTH`, 128, word width; must match the attached RAM.
- `AW` (localparam) = $clog2(NUMBER_OF_LINES).

Ports:
- `clk` in 1: single clock. Also drives the RAM's `clk_w` and `clk_r`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous clear of all FIFO state.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: controller can accept a word.
- `in_data` in DATA_WIDTH: upstream word.
- `out_valid` out 1: head word valid.
- `out_ready` in 1: downstream accepts the head word.
- `out_data` out DATA_WIDTH: head word.
- `ram_w_en` out 1: to RAM `w_en`.
- `ram_addr_w` out AW: to RAM `addr_w`.
- `ram_wr_data` out DATA_WIDTH: to RAM `wr_data`.
- `ram_r_en` out 1: to RAM `r_en`.
- `ram_addr_r` out AW: to RAM `addr_r`.
- `ram_rd_data` in DATA_WIDTH: from RAM `rd_data`.
- `ram_mem_valid` in 1: from RAM `mem_valid`.
- `fullness` out AW+2: total words held = RAM words + in-flight read + skid words; maximum NUMBER_OF_LINES+2.

## Operation
- **Pointers.** `wp` and `rp` are AW+1 bits each, wrapping naturally.
  - `ram_cnt = wp − rp`.
  - RAM empty when `ram_cnt == 0`; RAM full when `ram_cnt == NUMBER_OF_LINES`.
  - `ram_addr_w = wp[AW-1:0]`, `ram_addr_r = rp[AW-1:0]`.
- **Write path.**
  - `ram_w_en = in_valid & in_ready & ~flush`.
  - `ram_wr_data = in_data`, combinational.
  - `wp` increments on `ram_w_en`.
- **in_ready.** Registered. Next value is `(ram_cnt_next < NUMBER_OF_LINES)`, where `ram_cnt_next` includes this cycle's write and read. It is forced to 0 while `flush` is high.
- **Prefetch (read path).**
  - `pop = out_valid & out_ready`.
  - `ram_r_en = ~flush & (ram_cnt != 0) & (skid_cnt + inflight − pop < 2)`. This contains a combinational path from `out_ready`; that path is accepted.
  - `rp` increments on `ram_r_en`.
  - `inflight` <= `ram_r_en`.
- **Skid buffer.**
  - 2 entries, FIFO order; `skid_cnt` ranges 0..2.
  - `ram_rd_data` is written into the skid buffer when `ram_mem_valid & ~drop`.
  - `out_valid = (skid_cnt != 0)`; `out_data` = skid head.
  - Capture and pop may occur in the same cycle; `skid_cnt` is then unchanged.
  - Overflow is impossible by the issue rule. The bench asserts `skid_cnt ≤ 2`.
- **Read/write address separation.** A read is only issued for entries written in an earlier cycle. Same-cycle read and write therefore never target the same address.
- **Flush.**
  - On the next edge: `wp`, `rp` and `skid_cnt` are cleared, and `in_ready` goes to 0 (it returns to 1 the following cycle).
  - If a read is in flight, `drop` <= 1. The matching `ram_mem_valid` is discarded and `drop` then clears.
  - Upstream must not present `in_valid` with `flush`. If it does, no write occurs.
- **fullness** = `ram_cnt + inflight + skid_cnt`, registered.

## Timing
- **Reset values.**
  - `wp = rp = 0`, `skid_cnt = 0`, `inflight = 0`, `drop = 0`, `fullness = 0`.
  - `in_ready = 0`, `out_valid = 0`, `ram_w_en = 0`, `ram_r_en = 0`.
  - `out_data` and skid contents are don't-care.
- **in_ready after reset.** Rises on the first edge after `rst_n` deasserts.
- **First-word latency.** Word accepted at edge T: `ram_r_en` high in cycle T+1, `ram_mem_valid` in cycle T+2, `out_valid` in cycle T+3.
- **Throughput.** With `out_ready` held high, one word per cycle in and out in steady state.
- **Capacity.** With `out_ready = 0`, the controller accepts NUMBER_OF_LINES+2 words: 2 fill the skid, N fill the RAM. `in_ready` drops the cycle after the RAM reaches full.
- **Wrap-around.** Pointer overflow is transparent; the extra MSB distinguishes full from empty.
- **Reset mid-operation.** Asynchronous return to reset values. Data is lost and no output is generated from any stale `ram_mem_valid`. The RAM's own `mem_valid` register is not reset, so the bench holds the RAM in step: `r_en = 0` during reset.

## Test plan
- **Reset.** Hold `rst_n` low 5 cycles with `in_valid = 1` → no `ram_w_en`, `out_valid = 0`, `fullness = 0`; `in_ready = 1` one cycle after release.
- **Single word.** Write 0xA5 at edge T with `out_ready = 1` → `out_valid` and `out_data = 0xA5` in cycle T+3 only; `fullness` returns to 0.
- **Streaming.** 100 incrementing words, `in_valid` and `out_ready` held high → output identical and in order, one per cycle after the 3-cycle fill; `fullness` ≤ 3.
- **Full and wrap.** N=16, `out_ready = 0`, offer 20 words → exactly 18 accepted, `fullness = 18`, `in_ready = 0`. Then drain and refill 3 times → order preserved across pointer wrap.
- **Random backpressure.** 30% `in_valid` and 50% `out_ready` for 2000 cycles → scoreboard match, no skid overflow, `fullness` matches the model every cycle.
- **Flush with read in flight.** Pulse `flush` in the cycle `ram_r_en = 1` → the following `ram_mem_valid` is discarded, `out_valid = 0`, `fullness = 0`. Next word written emerges correctly at `ram_addr_r = 0`.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO built on an external sync_dp_ram.
// The RAM's one-cycle read latency is hidden by a 2-entry skid buffer
// that is kept topped up by prefetching reads from the RAM.
module ram_fifo_ctrl #(
    parameter int NUMBER_OF_LINES = 16,
    parameter int DATA_WIDTH      = 128
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  ram_w_en,
    output logic [$clog2(NUMBER_OF_LINES)-1:0]    ram_addr_w,
    output logic [DATA_WIDTH-1:0]                 ram_wr_data,
    output logic                                  ram_r_en,
    output logic [$clog2(NUMBER_OF_LINES)-1:0]    ram_addr_r,
    input  logic [DATA_WIDTH-1:0]                 ram_rd_data,
    input  logic                                  ram_mem_valid,
    output logic [$clog2(NUMBER_OF_LINES)+1:0]    fullness
);

    localparam int AW = $clog2(NUMBER_OF_LINES);
    localparam logic [AW:0] DEPTH = (AW+1)'(NUMBER_OF_LINES);

    logic [AW:0]           wp;
    logic [AW:0]           rp;
    logic [AW:0]           ram_cnt;
    logic [AW:0]           ram_cnt_next;
    logic [1:0]            skid_cnt;
    logic [1:0]            skid_cnt_next;
    logic                  skid_head;
    logic [DATA_WIDTH-1:0] skid_mem [2];
    logic                  inflight;
    logic                  drop;
    logic                  pop;
    logic                  capture;
    logic [2:0]            pending;

    assign ram_cnt     = wp - rp;
    assign ram_addr_w  = wp[AW-1:0];
    assign ram_addr_r  = rp[AW-1:0];
    assign ram_wr_data = in_data;
    assign ram_w_en    = in_valid & in_ready & ~flush;

    assign out_valid = (skid_cnt != 2'd0);
    assign out_data  = skid_mem[skid_head];
    assign pop       = out_valid & out_ready;
    assign capture   = ram_mem_valid & ~drop;

    // Words that will occupy the skid once the outstanding read lands;
    // a new read is issued only if that leaves a free slot.
    assign pending  = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign ram_r_en = ~flush & (ram_cnt != '0) & (pending < 3'd2);

    // Next-cycle occupancy of RAM and skid buffer
    always_comb begin
        ram_cnt_next  = '0;
        skid_cnt_next = '0;
        if (!flush) begin
            ram_cnt_next  = ram_cnt + (AW+1)'(ram_w_en) - (AW+1)'(ram_r_en);
            skid_cnt_next = skid_cnt + 2'(capture) - 2'(pop);
        end
    end

    // Pointers, read tracking, ready and fullness registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= '0;
            rp        <= '0;
            inflight  <= 1'b0;
            drop      <= 1'b0;
            in_ready  <= 1'b0;
            skid_cnt  <= '0;
            skid_head <= 1'b0;
            fullness  <= '0;
        end else begin
            if (flush) begin
                wp        <= '0;
                rp        <= '0;
                skid_head <= 1'b0;
            end else begin
                if (ram_w_en) wp <= wp + 1'b1;
                if (ram_r_en) rp <= rp + 1'b1;
                if (pop)      skid_head <= ~skid_head;
            end
            inflight <= ram_r_en;
            drop     <= flush & inflight;
            in_ready <= ~flush & (ram_cnt_next < DEPTH);
            skid_cnt <= skid_cnt_next;
            fullness <= (AW+2)'(ram_cnt_next) + (AW+2)'(ram_r_en)
                      + (AW+2)'(skid_cnt_next);
        end
    end

    // Skid storage; capture slot is head+count, count is at most 1 here
    always_ff @(posedge clk) begin
        if (capture && !flush)
            skid_mem[skid_head ^ skid_cnt[0]] <= ram_rd_data;
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural sync_dp_ram alongside.
module tb_ram_fifo_ctrl;

    localparam int N  = 16;
    localparam int AW = $clog2(N);
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ram_w_en;
    logic [AW-1:0] ram_addr_w;
    logic [DW-1:0] ram_wr_data;
    logic          ram_r_en;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_rd_data = '0;
    logic          ram_mem_valid = 1'b0;
    logic [AW+1:0] fullness;

    logic [DW-1:0] ram_mem [N];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_pop_cyc = 0;
    int max_full = 0;
    int seq      = 0;
    logic [DW-1:0] q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.NUMBER_OF_LINES(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_w_en(ram_w_en), .ram_addr_w(ram_addr_w), .ram_wr_data(ram_wr_data),
        .ram_r_en(ram_r_en), .ram_addr_r(ram_addr_r), .ram_rd_data(ram_rd_data),
        .ram_mem_valid(ram_mem_valid), .fullness(fullness)
    );

    // Behavioural RAM: registered read data and mem_valid
    always @(posedge clk) begin
        if (ram_w_en) ram_mem[ram_addr_w] <= ram_wr_data;
        if (ram_r_en) ram_rd_data <= ram_mem[ram_addr_r];
        ram_mem_valid <= ram_r_en;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    // Scoreboard: fullness, ordering and skid bound checked every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            cyc++;
            check("fullness", DW'(fullness), DW'(q.size()));
            check("skid_cnt_le2", DW'(dut.skid_cnt <= 2'd2), 1);
            if (int'(fullness) > max_full) max_full = int'(fullness);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("pop_when_empty", 1, 0);
                else begin
                    check("out_data", out_data, q[0]);
                    void'(q.pop_front());
                end
                last_pop_cyc = cyc;
            end
            check("w_en", DW'(ram_w_en), DW'(in_valid & in_ready & ~flush));
            if (in_valid && in_ready && !flush) q.push_back(in_data);
            if (flush) q.delete();
        end
    end

    // Offer up to n_words sequential words within budget cycles
    task automatic offer(input int n_words, input int budget, output int acc);
        acc = 0;
        tick();
        in_valid = 1'b1;
        in_data  = DW'(seq);
        for (int c = 0; c < budget && acc < n_words; c++) begin
            sample();
            if (in_ready) begin acc++; seq++; end
            tick();
            in_data  = DW'(seq);
            in_valid = (acc < n_words);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 80 && q.size() != 0; k++) sample();
        sample();
        check({tag, "_empty"}, DW'(q.size()), 0);
        check({tag, "_fullness"}, DW'(fullness), 0);
        check({tag, "_out_valid"}, DW'(out_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int s;
        int i;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 128'h1; out_ready = 1'b0;

        // Reset held with in_valid asserted
        repeat (5) begin
            sample();
            check("rst_w_en", DW'(ram_w_en), 0);
            check("rst_out_valid", DW'(out_valid), 0);
            check("rst_fullness", DW'(fullness), 0);
            check("rst_in_ready", DW'(in_ready), 0);
        end
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        sample();
        check("in_ready_before_edge", DW'(in_ready), 0);
        tick();
        sample();
        check("in_ready_after_edge", DW'(in_ready), 1);

        // Single word latency
        tick();
        in_valid = 1'b1; in_data = 128'hA5; out_ready = 1'b1;
        sample();
        check("sw_w_en", DW'(ram_w_en), 1);
        check("sw_addr_w", DW'(ram_addr_w), 0);
        tick();
        in_valid = 1'b0;
        sample();
        check("sw_r_en", DW'(ram_r_en), 1);
        check("sw_addr_r", DW'(ram_addr_r), 0);
        check("sw_ov_t1", DW'(out_valid), 0);
        tick();
        sample();
        check("sw_mem_valid", DW'(ram_mem_valid), 1);
        check("sw_ov_t2", DW'(out_valid), 0);
        tick();
        sample();
        check("sw_ov_t3", DW'(out_valid), 1);
        check("sw_data", out_data, 128'hA5);
        tick();
        sample();
        check("sw_ov_t4", DW'(out_valid), 0);
        check("sw_fullness", DW'(fullness), 0);

        // Streaming 100 words at full rate
        tick();
        max_full = 0; out_ready = 1'b1; in_valid = 1'b1; i = 0; s = -1;
        in_data = DW'(1000);
        for (int c = 0; c < 300 && i < 100; c++) begin
            sample();
            if (s < 0) s = cyc;
            if (in_ready) i++;
            tick();
            in_data  = DW'(1000 + i);
            in_valid = (i < 100);
        end
        for (int k = 0; k < 50 && q.size() != 0; k++) sample();
        check("stream_accepted", DW'(i), 100);
        check("stream_drained", DW'(q.size()), 0);
        check("stream_span", DW'(last_pop_cyc - s), 102);
        check("stream_max_full", DW'(max_full <= 3), 1);

        // Fill to capacity with output stalled, then drain/refill across wrap
        tick();
        out_ready = 1'b0;
        offer(20, 40, acc);
        sample();
        check("full_accepted", DW'(acc), 18);
        check("full_fullness", DW'(fullness), 18);
        check("full_in_ready", DW'(in_ready), 0);
        check("full_out_valid", DW'(out_valid), 1);
        for (int r = 0; r < 3; r++) begin
            drain("wrap_drain");
            tick();
            out_ready = 1'b0;
            offer(20, 40, acc);
            sample();
            check("refill_accepted", DW'(acc), 18);
            check("refill_fullness", DW'(fullness), 18);
        end
        drain("wrap_final");

        // Random traffic and backpressure
        for (int c = 0; c < 2000; c++) begin
            tick();
            in_valid  = ($urandom_range(0, 99) < 30);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 99) < 50);
        end
        drain("rand_drain");

        // Flush in the cycle a read would issue
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h1111;
        sample();
        check("fl1_w_en", DW'(ram_w_en), 1);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        sample();
        check("fl1_r_en_gated", DW'(ram_r_en), 0);
        tick();
        flush = 1'b0;
        sample();
        check("fl1_out_valid", DW'(out_valid), 0);
        check("fl1_fullness", DW'(fullness), 0);
        check("fl1_in_ready_low", DW'(in_ready), 0);
        check("fl1_no_mem_valid", DW'(ram_mem_valid), 0);
        tick();
        sample();
        check("fl1_in_ready_back", DW'(in_ready), 1);

        // Flush while a read is in flight
        tick();
        in_valid = 1'b1; in_data = 128'h2222;
        sample();
        tick();
        in_valid = 1'b0;
        sample();
        check("fl2_r_en", DW'(ram_r_en), 1);
        tick();
        flush = 1'b1;
        sample();
        check("fl2_mem_valid", DW'(ram_mem_valid), 1);
        check("fl2_fullness_inflight", DW'(fullness), 1);
        tick();
        flush = 1'b0;
        sample();
        check("fl2_out_valid", DW'(out_valid), 0);
        check("fl2_fullness", DW'(fullness), 0);
        check("fl2_drop_set", DW'(dut.drop), 1);
        tick();
        sample();
        check("fl2_out_valid_late", DW'(out_valid), 0);
        check("fl2_drop_clear", DW'(dut.drop), 0);

        // First word after flush lands at address 0
        tick();
        in_valid = 1'b1; in_data = 128'h5A5A; out_ready = 1'b1;
        sample();
        check("pf_w_en", DW'(ram_w_en), 1);
        check("pf_addr_w", DW'(ram_addr_w), 0);
        tick();
        in_valid = 1'b0;
        sample();
        check("pf_r_en", DW'(ram_r_en), 1);
        check("pf_addr_r", DW'(ram_addr_r), 0);
        tick();
        sample();
        tick();
        sample();
        check("pf_out_valid", DW'(out_valid), 1);
        check("pf_out_data", out_data, 128'h5A5A);
        tick();
        sample();
        check("pf_fullness", DW'(fullness), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
